// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
//   Fetch stage for a 2^ADDR_W-word, word-addressed instruction memory. It owns
//   the PC, presents it as the memory address, and captures the word returned
//   in the same cycle into the IF/ID pipeline register. It supports a hazard
//   stall and a redirect (EX branch or ID jump) that flushes IF/ID. It also
//   keeps saturating counters of captured instructions and flush bubbles.
//
// Ports
//   clk, rst         clock; synchronous active-high reset
//   stall            hold PC and IF/ID
//   branch_taken     EX branch taken; PC <= branch_target
//   branch_target    absolute word address of the branch
//   jump             ID jump; PC <= jump_target (loses to branch_taken)
//   jump_target      absolute word address of the jump
//   imem_addr        address to the instruction memory (= pc)
//   imem_instr       instruction word returned combinationally
//   pc               current fetch PC
//   if_id_instr      registered instruction for decode (0 = NOP)
//   if_id_pc_plus1   registered fetch PC + 1, wrapped
//   if_id_valid      IF/ID holds a real instruction (0 = bubble)
//   fetch_cnt        saturating count of valid captures
//   bubble_cnt       saturating count of flush bubbles
// -----------------------------------------------------------------------------
module instruction_fetch #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_target,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_instr,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] if_id_instr,
  output logic [ADDR_W-1:0] if_id_pc_plus1,
  output logic              if_id_valid,
  output logic [CNT_W-1:0]  fetch_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

  logic [ADDR_W-1:0] pc_r;
  logic [DATA_W-1:0] instr_r;
  logic [ADDR_W-1:0] pc_plus1_r;
  logic              valid_r;
  logic [CNT_W-1:0]  fetch_cnt_r;
  logic [CNT_W-1:0]  bubble_cnt_r;

  logic [ADDR_W-1:0] pc_inc_s;
  logic [ADDR_W-1:0] next_pc_s;
  logic              redirect_s;

  // Natural wrap of the ADDR_W-bit add gives the 31 -> 0 rollover.
  assign pc_inc_s   = pc_r + ADDR_ONE;
  assign redirect_s = branch_taken | jump;

  // Next-PC selection: branch (older instruction) beats jump, redirect beats stall.
  always_comb begin
    next_pc_s = pc_inc_s;
    if (branch_taken) begin
      next_pc_s = branch_target;
    end else if (jump) begin
      next_pc_s = jump_target;
    end else if (stall) begin
      next_pc_s = pc_r;
    end else begin
      next_pc_s = pc_inc_s;
    end
  end

  // PC register.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r <= {ADDR_W{1'b0}};
    end else begin
      pc_r <= next_pc_s;
    end
  end

  // IF/ID register: flush on redirect, hold on stall, otherwise capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_r    <= {DATA_W{1'b0}};
      pc_plus1_r <= {ADDR_W{1'b0}};
      valid_r    <= 1'b0;
    end else if (redirect_s) begin
      instr_r    <= {DATA_W{1'b0}};
      pc_plus1_r <= {ADDR_W{1'b0}};
      valid_r    <= 1'b0;
    end else if (!stall) begin
      instr_r    <= imem_instr;
      pc_plus1_r <= pc_inc_s;
      valid_r    <= 1'b1;
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_r  <= {CNT_W{1'b0}};
      bubble_cnt_r <= {CNT_W{1'b0}};
    end else if (redirect_s) begin
      if (bubble_cnt_r != CNT_MAX) begin
        bubble_cnt_r <= bubble_cnt_r + CNT_ONE;
      end
    end else if (!stall) begin
      if (fetch_cnt_r != CNT_MAX) begin
        fetch_cnt_r <= fetch_cnt_r + CNT_ONE;
      end
    end
  end

  assign imem_addr      = pc_r;
  assign pc             = pc_r;
  assign if_id_instr    = instr_r;
  assign if_id_pc_plus1 = pc_plus1_r;
  assign if_id_valid    = valid_r;
  assign fetch_cnt      = fetch_cnt_r;
  assign bubble_cnt     = bubble_cnt_r;

endmodule
